// File: rtl/sub_serial_nbit.sv
// rtl/sub_serial_nbit.sv - bit-serial WIDTH-bit subtractor (A - B), LSB first, one borrow flop.
// Optional signed-overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_w;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             bit_a, bit_b, d, br_next;
  logic             last, load;

`ifdef SUB_SERIAL_OVF_EN
  logic a_msb, b_msb;
`endif

  assign bit_a   = a_sr[0];
  assign bit_b   = b_sr[0];
  assign d       = bit_a ^ bit_b ^ br;
  assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
  // Result bits accumulate from the MSB end; the full word is {current bit, history}.
  assign res_w   = {d, res_sr};
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign load    = start && (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf_out    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (load) begin
        a_sr   <= a_in;
        b_sr   <= b_in;
        res_sr <= '0;
        cnt    <= '0;
        br     <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
        a_msb  <= a_in[WIDTH-1];
        b_msb  <= b_in[WIDTH-1];
`endif
      end else if (state == RUN) begin
        a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
        res_sr <= res_w[WIDTH-1:1];
        br     <= br_next;
        cnt    <= cnt + 1'b1;
        if (last) begin
          diff_out   <= res_w;
          borrow_out <= br_next;
`ifdef SUB_SERIAL_OVF_EN
          // d is the result MSB on the final bit.
          ovf_out    <= (a_msb != b_msb) && (d != a_msb);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_serial_nbit.sv
// tb/tb_sub_serial_nbit.sv - directed and exhaustive checks of sub_serial_nbit (WIDTH 8 and 4).
module tb_sub_serial_nbit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       busy8, done8, borrow8, busy4, done4, borrow4;
`ifdef SUB_SERIAL_OVF_EN
  logic       ovf8, ovf4;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sub_serial_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .diff_out(diff8), .borrow_out(borrow8)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf_out(ovf8)
`endif
  );

  sub_serial_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .diff_out(diff4), .borrow_out(borrow4)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf_out(ovf4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Drives a one-cycle start from a falling edge; lat counts edges until done is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int sa, sb, sd;
    logic [3:0] ed;
    logic eb, eo;

    vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_diff", diff8, 0);
    check("reset_borrow", borrow8, 0);
`ifdef SUB_SERIAL_OVF_EN
    check("reset_ovf", ovf8, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_diff", i), diff8, vecs[i].diff);
      check($sformatf("vec%0d_borrow", i), borrow8, vecs[i].borrow);
`ifdef SUB_SERIAL_OVF_EN
      check($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ovf);
`endif
    end

    // Start while busy is ignored; start during DONE is accepted without an IDLE bubble.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h50; b8 = 8'h20;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    check("busy_after_start", busy8, 1);
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 4) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
    end
    check("ignore_latency", lat, 9);
    check("ignore_diff", diff8, 8'h30);
    check("ignore_borrow", borrow8, 0);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy", busy8, 1);
    check("b2b_done_low", done8, 0);
    lat = 1;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", lat, 9);
    check("b2b_diff", diff8, 8'hF0);
    check("b2b_borrow", borrow8, 1);
    @(negedge clk);
    check("done_one_cycle", done8, 0);

    // Reset mid-run discards the partial result; same-cycle start is dropped.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h12;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    @(negedge clk);
    start8 = 1'b0;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_diff", diff8, 0);
    check("midrst_borrow", borrow8, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_start_dropped", busy8, 0);
    run8(8'hAA, 8'h55, lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_diff", diff8, 8'h55);
    check("post_rst_borrow", borrow8, 0);

    // Exhaustive 4-bit sweep against signed/unsigned integer arithmetic.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b), lat);
        ed = 4'((a - b + 16) % 16);
        eb = (a < b);
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        sd = sa - sb;
        eo = (sd > 7) || (sd < -8);
        if (lat != 5) begin
          check($sformatf("w4_latency_%0h_%0h", a, b), lat, 5);
        end else begin
`ifdef SUB_SERIAL_OVF_EN
          check($sformatf("w4_%0h_%0h", a, b), {diff4, borrow4, ovf4}, {ed, eb, eo});
`else
          check($sformatf("w4_%0h_%0h", a, b), {diff4, borrow4}, {ed, eb});
`endif
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
